// File: rtl/fu_seq_pkg.sv
// Shared opcode, FunctionalUnit select and state definitions for the FunctionalUnit op sequencer.
package fu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_PASS_A = 4'b1000;
  localparam logic [3:0] OP_PASS_B = 4'b1001;
  localparam logic [3:0] OP_SHL_N  = 4'b1010;
  localparam logic [3:0] OP_SHR_N  = 4'b1011;

  localparam logic [2:0] FS_SHL = 3'b110;
  localparam logic [2:0] FS_SHR = 3'b111;

  function automatic logic op_illegal(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic op_is_shift_n(input logic [3:0] op);
    return (op == OP_SHL_N) || (op == OP_SHR_N);
  endfunction

endpackage

// File: rtl/fu_op_sequencer.sv
// Multi-cycle controller for the FunctionalUnit: single-pass ops, pass-through,
// and shift-by-N built from repeated single-bit shifts through an accumulator.
module fu_op_sequencer
  import fu_seq_pkg::*;
#(
  parameter int NBIT  = 16,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [NBIT-1:0] cmd_a,
  input  logic [NBIT-1:0] cmd_b,
  output logic [2:0]      fu_fs,
  output logic [NBIT-1:0] fu_a,
  output logic [NBIT-1:0] fu_b,
  output logic            fu_a_thru,
  output logic            fu_b_thru,
  input  logic [NBIT-1:0] fu_out,
  input  logic            fu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NBIT-1:0] res_data,
  output logic            res_zero,
  output logic            res_err
);

  state_t           r_state;
  logic [3:0]       r_op;
  logic [NBIT-1:0]  r_a;
  logic [NBIT-1:0]  r_b;
  logic [NBIT-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic             r_res_valid;
  logic [NBIT-1:0]  r_res_data;
  logic             r_res_zero;
  logic             r_res_err;
  logic             w_accept;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_zero  = r_res_zero;
  assign res_err   = r_res_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op;
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_acc       <= cmd_a;
            r_cnt       <= cmd_b[CNT_W-1:0];
            r_cmd_ready <= 1'b0;
            if (op_illegal(cmd_op)) begin
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
              r_res_data  <= '0;
              r_res_zero  <= 1'b0;
              r_res_err   <= 1'b1;
            end else if (op_is_shift_n(cmd_op) && (cmd_b[CNT_W-1:0] != '0)) begin
              r_state <= S_SHIFT;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_res_data  <= fu_out;
          r_res_zero  <= fu_zero;
          r_res_err   <= 1'b0;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_SHIFT: begin
          r_acc <= fu_out;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_res_data  <= fu_out;
            r_res_zero  <= fu_zero;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FunctionalUnit drive decodes only registered state, so it is glitch-free and zero in reset.
  always_comb begin
    fu_fs     = '0;
    fu_a      = '0;
    fu_b      = '0;
    fu_a_thru = 1'b0;
    fu_b_thru = 1'b0;
    case (r_state)
      S_EXEC: begin
        fu_a = r_a;
        fu_b = r_b;
        if (!r_op[3]) begin
          fu_fs = r_op[2:0];
        end else if (r_op == OP_PASS_B) begin
          fu_b_thru = 1'b1;
        end else begin
          fu_a_thru = 1'b1;
        end
      end
      S_SHIFT: begin
        fu_a  = r_acc;
        fu_fs = (r_op == OP_SHL_N) ? FS_SHL : FS_SHR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fu_op_sequencer.sv
// Self-checking bench: a stand-in FunctionalUnit beside the sequencer, directed and random commands.
module tb_fu_op_sequencer;

  localparam int NBIT  = 16;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_op;
  logic [NBIT-1:0] cmd_a;
  logic [NBIT-1:0] cmd_b;
  logic [2:0]      fu_fs;
  logic [NBIT-1:0] fu_a;
  logic [NBIT-1:0] fu_b;
  logic            fu_a_thru;
  logic            fu_b_thru;
  logic [NBIT-1:0] fu_out;
  logic            fu_zero;
  logic            res_valid;
  logic            res_ready;
  logic [NBIT-1:0] res_data;
  logic            res_zero;
  logic            res_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_op_sequencer #(.NBIT(NBIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .fu_fs(fu_fs), .fu_a(fu_a), .fu_b(fu_b),
    .fu_a_thru(fu_a_thru), .fu_b_thru(fu_b_thru),
    .fu_out(fu_out), .fu_zero(fu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_err(res_err)
  );

  function automatic logic [15:0] fu_func(input logic [2:0] fs, input logic [15:0] a, input logic [15:0] b);
    case (fs)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {a[14:0], 1'b0};
      default: return {1'b0, a[15:1]};
    endcase
  endfunction

  // Stand-in FunctionalUnit
  always_comb begin
    fu_out = '0;
    if (fu_a_thru)      fu_out = fu_a;
    else if (fu_b_thru) fu_out = fu_b;
    else                fu_out = fu_func(fu_fs, fu_a, fu_b);
    fu_zero = (fu_out == '0);
  end

  // Reference result {err, zero, data} computed directly from the opcode rules
  function automatic logic [17:0] ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    int n;
    n = int'(b[3:0]);
    if (op[3:2] == 2'b11) return {1'b1, 1'b0, 16'h0000};
    if (!op[3])               d = fu_func(op[2:0], a, b);
    else if (op == 4'b1000)   d = a;
    else if (op == 4'b1001)   d = b;
    else if (op == 4'b1010)   d = 16'((32'(a) << n));
    else                      d = 16'((32'(a) >> n));
    return {1'b0, (d == 16'h0000), d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int stall);
    logic [17:0] exp;
    logic        is_shift;
    logic        illegal;
    int          n;
    int          lat;
    int          cyc;
    logic [2:0]  exp_fs;
    exp      = ref_model(op, a, b);
    n        = int'(b[3:0]);
    illegal  = (op[3:2] == 2'b11);
    is_shift = (op == 4'b1010) || (op == 4'b1011);
    lat      = illegal ? 0 : ((is_shift && n != 0) ? n : 1);
    if (illegal)                exp_fs = 3'b000;
    else if (!op[3])            exp_fs = op[2:0];
    else if (is_shift && n != 0) exp_fs = {2'b11, op[0]};
    else                        exp_fs = 3'b000;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);

    check("fu_fs_first", fu_fs, exp_fs);
    check("fu_a_first", fu_a, illegal ? 16'h0 : a);
    check("fu_b_first", fu_b, (illegal || (is_shift && n != 0)) ? 16'h0 : b);
    check("fu_a_thru_first", fu_a_thru, !illegal && (op == 4'b1000 || (is_shift && n == 0)));
    check("fu_b_thru_first", fu_b_thru, op == 4'b1001);
    check("cmd_ready_busy", cmd_ready, 0);

    cyc = 0;
    while (!res_valid && cyc < 40) begin
      check("fu_fs_busy", fu_fs, exp_fs);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, lat);
    check("res_data", res_data, exp[15:0]);
    check("res_zero", res_zero, exp[16]);
    check("res_err", res_err, exp[17]);

    repeat (stall) begin
      @(posedge clk); #1;
      check("stall_valid", res_valid, 1);
      check("stall_data", res_data, exp[15:0]);
      check("stall_err", res_err, exp[17]);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_fu_fs", fu_fs, 0);
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("release_valid", res_valid, 0);
    check("release_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_res_err", res_err, 0);
    check("rst_fu_fs", fu_fs, 0);
    check("rst_fu_a", fu_a, 0);
    @(negedge clk); rst_n = 1'b1;

    run_cmd(4'b0010, 16'h1234, 16'h0F0F, 0);
    run_cmd(4'b1010, 16'h0001, 16'h0003, 0);
    run_cmd(4'b1011, 16'h8000, 16'h000F, 1);
    run_cmd(4'b1010, 16'h8000, 16'h0001, 0);
    run_cmd(4'b1001, 16'h1111, 16'hBEEF, 0);
    run_cmd(4'b1010, 16'h00A5, 16'h0000, 0);
    run_cmd(4'b1010, 16'h00A5, 16'hFFF2, 0);
    run_cmd(4'b1100, 16'h5555, 16'hAAAA, 5);
    run_cmd(4'b0110, 16'h4001, 16'h0000, 0);
    run_cmd(4'b0111, 16'h0003, 16'h0000, 0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset mid-SHIFT
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'b1010; cmd_a = 16'h0001; cmd_b = 16'h000A;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_shift_fs", fu_fs, 3'b110);
    rst_n = 1'b0; #1;
    check("abort_shift_valid", res_valid, 0);
    check("abort_shift_cmd_ready", cmd_ready, 1);
    check("abort_shift_fu_fs", fu_fs, 0);
    check("abort_shift_fu_a", fu_a, 0);
    check("abort_shift_thru", {fu_a_thru, fu_b_thru}, 0);
    @(negedge clk); rst_n = 1'b1;
    run_cmd(4'b1000, 16'hC0DE, 16'h0000, 0);

    // Reset mid-DONE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'b1111; cmd_a = 16'h0; cmd_b = 16'h0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    check("pre_rst_done_valid", res_valid, 1);
    #2; rst_n = 1'b0; #1;
    check("abort_done_valid", res_valid, 0);
    check("abort_done_err", res_err, 0);
    check("abort_done_cmd_ready", cmd_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    run_cmd(4'b1000, 16'h0000, 16'h1234, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
